// File: rtl/wb_bram_arb_pkg.sv
// Shared state encoding and master indices for the two-master Wishbone-to-BRAM arbiter.
package wb_bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One-hot {m1,m0} owner view of a state.
  function automatic logic [1:0] grant_of(input arb_state_e s);
    return {s == ST_GNT1, s == ST_GNT0};
  endfunction

endpackage

// File: rtl/wb_bram_arbiter.sv
// Round-robin, non-preemptive arbiter letting two pipelined Wishbone masters share
// one port of a 1-cycle-latency BRAM; acks follow accepted strobes by one cycle.
module wb_bram_arbiter
  import wb_bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,

  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  output logic                  o_m0_stall,
  output logic                  o_m0_ack,
  output logic [DATA_WIDTH-1:0] o_m0_data,

  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  output logic                  o_m1_stall,
  output logic                  o_m1_ack,
  output logic [DATA_WIDTH-1:0] o_m1_data,

  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,

  output logic [1:0]            o_grant
);

  arb_state_e state, state_nx;
  logic       last, last_nx;
  logic       acc0_p0, acc1_p0;
  logic       ack0_p1, ack1_p1;
  logic       own1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      last    <= M1;
      ack0_p1 <= 1'b0;
      ack1_p1 <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      ack0_p1 <= acc0_p0;
      ack1_p1 <= acc1_p0;
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    o_m0_stall = 1'b1;
    o_m1_stall = 1'b1;
    case (state)
      ST_IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_nx = (last == M1) ? ST_GNT0 : ST_GNT1;
        else if (i_m0_cyc)        state_nx = ST_GNT0;
        else if (i_m1_cyc)        state_nx = ST_GNT1;
      end
      ST_GNT0: begin
        o_m0_stall = 1'b0;
        if (!i_m0_cyc) state_nx = i_m1_cyc ? ST_GNT1 : ST_IDLE;
      end
      ST_GNT1: begin
        o_m1_stall = 1'b0;
        if (!i_m1_cyc) state_nx = i_m0_cyc ? ST_GNT0 : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Pointer only moves when a grant is newly handed out; holding leaves it alone.
    if (state_nx == ST_GNT0 && state != ST_GNT0) last_nx = M0;
    if (state_nx == ST_GNT1 && state != ST_GNT1) last_nx = M1;
  end

  // Stage p0: accepted strobe drives the BRAM port directly
  assign own1    = (state == ST_GNT1);
  assign acc0_p0 = (state == ST_GNT0) & i_m0_cyc & i_m0_stb & ~i_reset;
  assign acc1_p0 = (state == ST_GNT1) & i_m1_cyc & i_m1_stb & ~i_reset;

  assign o_ram_en   = acc0_p0 | acc1_p0;
  assign o_ram_we   = (acc0_p0 & i_m0_we) | (acc1_p0 & i_m1_we);
  assign o_ram_addr = own1 ? i_m1_addr : i_m0_addr;
  assign o_ram_din  = own1 ? i_m1_data : i_m0_data;

  // Stage p1: BRAM data returns; ack dropped if the master abandoned its cycle
  assign o_m0_ack  = ack0_p1 & i_m0_cyc & ~i_reset;
  assign o_m1_ack  = ack1_p1 & i_m1_cyc & ~i_reset;
  assign o_m0_data = o_m0_ack ? i_ram_dout : '0;
  assign o_m1_data = o_m1_ack ? i_ram_dout : '0;

  assign o_grant = grant_of(state);

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Bench for wb_bram_arbiter: vector table, directed multi-cycle sequences and a
// randomized run scored against a transaction-level model with its own memory image.
module tb_wb_bram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_stall, m0_ack, m1_stall, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [1:0]    grant;

  wb_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
    .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .o_m0_stall(m0_stall), .o_m0_ack(m0_ack), .o_m0_data(m0_rdata),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
    .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m1_stall(m1_stall), .o_m1_ack(m1_ack), .o_m1_data(m1_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout),
    .o_grant(grant)
  );

  // Behavioural 1-cycle-latency BRAM with a backdoor write port for preloading.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic c0, input logic s0, input logic w0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic c1, input logic s1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_cyc = c0; m0_stb = s0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_cyc = c1; m1_stb = s1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct packed {
    logic       rst, c0, s0, w0, c1, s1, w1;
    logic [1:0] grant;
    logic       st0, st1, en, ack0, ack1;
  } vec_t;

  vec_t vt [16];

  // Random-phase reference model state
  int            owner, lastg;
  bit            pend [2];
  bit            pend_rd [2];
  logic [DW-1:0] pend_d [2];
  logic [DW-1:0] ref_mem [16];
  bit            c [2];
  bit            s [2];
  bit            w [2];
  logic [3:0]    a [2];
  logic [DW-1:0] d [2];
  bit            exp_en, exp_ack;

  initial begin
    // {rst,c0,s0,w0,c1,s1,w1} , {grant,st0,st1,en,ack0,ack1}
    vt[0]  = {7'b0_100_100, 7'b00_11_000};  // tie after reset: nobody yet
    vt[1]  = {7'b0_110_100, 7'b01_01_100};  // M0 won the tie, read accepted
    vt[2]  = {7'b0_000_100, 7'b01_01_000};  // M0 drops cyc: ack aborted
    vt[3]  = {7'b0_000_111, 7'b10_10_100};  // handed to M1 with no gap
    vt[4]  = {7'b0_000_110, 7'b10_10_101};
    vt[5]  = {7'b0_000_000, 7'b10_10_000};  // M1 abort of read ack
    vt[6]  = {7'b0_100_100, 7'b00_11_000};  // second tie
    vt[7]  = {7'b0_110_100, 7'b01_01_100};  // M0 wins again (M1 was last)
    vt[8]  = {7'b0_110_100, 7'b01_01_110};
    vt[9]  = {7'b0_000_111, 7'b01_01_000};  // stalled M1 strobe ignored
    vt[10] = {7'b0_000_111, 7'b10_10_100};
    vt[11] = {7'b1_000_111, 7'b10_10_000};  // reset mid-burst
    vt[12] = {7'b0_100_111, 7'b00_11_000};
    vt[13] = {7'b0_100_100, 7'b01_01_000};  // tie after reset -> M0
    vt[14] = {7'b0_000_000, 7'b01_01_000};
    vt[15] = {7'b0_000_000, 7'b00_11_000};

    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    idle();
    tick(); tick();
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_stall0", m0_stall, 1'b1);
    chk("rst_stall1", m1_stall, 1'b1);
    chk("rst_ack0", m0_ack, 1'b0);
    chk("rst_ack1", m1_ack, 1'b0);
    chk("rst_en", ram_en, 1'b0);

    for (int i = 0; i < 16; i++) begin
      tick();
      rst = vt[i].rst;
      drive(vt[i].c0, vt[i].s0, vt[i].w0, AW'(7), DW'(32'hA5A5_0000 + i),
            vt[i].c1, vt[i].s1, vt[i].w1, AW'(9), DW'(32'h5A5A_0000 + i));
      settle();
      chk($sformatf("vec%0d_grant", i), grant, vt[i].grant);
      chk($sformatf("vec%0d_stall0", i), m0_stall, vt[i].st0);
      chk($sformatf("vec%0d_stall1", i), m1_stall, vt[i].st1);
      chk($sformatf("vec%0d_ram_en", i), ram_en, vt[i].en);
      chk($sformatf("vec%0d_ack0", i), m0_ack, vt[i].ack0);
      chk($sformatf("vec%0d_ack1", i), m1_ack, vt[i].ack1);
      if (!vt[i].ack0) chk($sformatf("vec%0d_data0", i), m0_rdata, '0);
      if (!vt[i].ack1) chk($sformatf("vec%0d_data1", i), m1_rdata, '0);
    end
    rst = 1'b0;

    // Single read of a preloaded word
    tick(); idle(); bd_we = 1'b1; bd_addr = AW'(5); bd_data = 32'hDEAD_BEEF;
    tick(); bd_we = 1'b0;
    tick(); drive(1'b1, 1'b0, 1'b0, AW'(5), '0, 1'b0, 1'b0, 1'b0, '0, '0); settle();
    chk("rd_wait_grant", grant, 2'b00);
    tick(); drive(1'b1, 1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, 1'b0, '0, '0); settle();
    chk("rd_grant", grant, 2'b01);
    chk("rd_en", ram_en, 1'b1);
    chk("rd_we", ram_we, 1'b0);
    chk("rd_addr", ram_addr, 5);
    tick(); drive(1'b1, 1'b0, 1'b0, AW'(5), '0, 1'b0, 1'b0, 1'b0, '0, '0); settle();
    chk("rd_ack0", m0_ack, 1'b1);
    chk("rd_data0", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_ack1", m1_ack, 1'b0);
    chk("rd_data1", m1_rdata, '0);
    tick(); idle(); settle();
    chk("rd_ack0_once", m0_ack, 1'b0);
    chk("rd_data0_zero", m0_rdata, '0);

    // Starvation: M1 waits while M0 holds the bus
    tick(); drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0); settle();
    for (int i = 0; i < 20; i++) begin
      tick(); drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, AW'(2), '0); settle();
      chk($sformatf("starve%0d_grant", i), grant, 2'b01);
      chk($sformatf("starve%0d_stall1", i), m1_stall, 1'b1);
      chk($sformatf("starve%0d_ack1", i), m1_ack, 1'b0);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, AW'(2), '0); settle();
    chk("starve_rel_stall1", m1_stall, 1'b1);
    tick(); settle();
    chk("starve_gnt", grant, 2'b10);
    chk("starve_gnt_stall1", m1_stall, 1'b0);
    chk("starve_gnt_en", ram_en, 1'b1);
    tick(); drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0); settle();
    chk("starve_ack1", m1_ack, 1'b1);
    tick(); idle();
    tick();

    // Pipelined burst: 4 writes then 4 reads by M1
    tick(); drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0); settle();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, AW'(i), DW'(32'h11 * (i + 1)));
      else       drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
      settle();
      if (i < 4) begin
        chk($sformatf("bw%0d_en", i), ram_en, 1'b1);
        chk($sformatf("bw%0d_we", i), ram_we, 1'b1);
      end
      chk($sformatf("bw%0d_ack1", i), m1_ack, i >= 1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, AW'(i), '0);
      else       drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
      settle();
      chk($sformatf("br%0d_ack1", i), m1_ack, i >= 1);
      if (i >= 1) chk($sformatf("br%0d_data1", i), m1_rdata, 32'h11 * i);
    end
    tick(); idle();

    // Randomized run against the reference model
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      bd_we = 1'b1; bd_addr = AW'(k); bd_data = ref_mem[k];
      tick();
    end
    bd_we = 1'b0;
    owner = -1; lastg = 1;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; pend_rd[n] = 1'b0; pend_d[n] = '0; c[n] = 1'b0;
    end
    for (int cy = 0; cy < 400; cy++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (c[n]) c[n] = ($urandom_range(0, 7) != 0);
        else      c[n] = ($urandom_range(0, 2) == 0);
        s[n] = c[n] && ($urandom_range(0, 1) == 1);
        w[n] = ($urandom_range(0, 1) == 1);
        a[n] = 4'($urandom_range(0, 15));
        d[n] = $urandom;
      end
      drive(c[0], s[0], w[0], AW'(a[0]), d[0], c[1], s[1], w[1], AW'(a[1]), d[1]);
      settle();
      chk($sformatf("rnd%0d_grant", cy), grant, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
      chk($sformatf("rnd%0d_stall0", cy), m0_stall, owner != 0);
      chk($sformatf("rnd%0d_stall1", cy), m1_stall, owner != 1);
      exp_en = (owner >= 0) && c[owner] && s[owner];
      chk($sformatf("rnd%0d_en", cy), ram_en, exp_en);
      if (exp_en) begin
        chk($sformatf("rnd%0d_we", cy), ram_we, w[owner]);
        chk($sformatf("rnd%0d_addr", cy), ram_addr, a[owner]);
        if (w[owner]) chk($sformatf("rnd%0d_din", cy), ram_din, d[owner]);
      end
      for (int n = 0; n < 2; n++) begin
        exp_ack = pend[n] && c[n];
        chk($sformatf("rnd%0d_ack%0d", cy, n), n == 0 ? m0_ack : m1_ack, exp_ack);
        if (exp_ack && pend_rd[n])
          chk($sformatf("rnd%0d_data%0d", cy, n), n == 0 ? m0_rdata : m1_rdata, pend_d[n]);
        else if (!exp_ack)
          chk($sformatf("rnd%0d_data%0d", cy, n), n == 0 ? m0_rdata : m1_rdata, '0);
      end
      // Advance the model across the clock edge
      for (int n = 0; n < 2; n++) begin
        pend[n] = (owner == n) && c[n] && s[n];
        if (pend[n]) begin
          pend_rd[n] = !w[n];
          if (w[n]) ref_mem[a[n]] = d[n];
          else      pend_d[n] = ref_mem[a[n]];
        end
      end
      if (owner < 0) begin
        if (c[0] && c[1]) owner = (lastg == 1) ? 0 : 1;
        else if (c[0])    owner = 0;
        else if (c[1])    owner = 1;
        if (owner >= 0) lastg = owner;
      end else if (!c[owner]) begin
        owner = c[1 - owner] ? 1 - owner : -1;
        if (owner >= 0) lastg = owner;
      end
    end
    tick(); idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
